// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch pipeline: word type, fetch FSM states, bubble encoding
// and the word-alignment helper used on redirect targets.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t BUBBLE_INSTR = 32'h0000_0000;

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC candidates: prioritised redirect target (branch > jr > jump, word aligned)
// and the sequential PC+4, which wraps naturally at 2^32.
module pc_next_mux
    import cpu_types_pkg::*;
(
    input  logic  val_brnch,
    input  word_t brnch_addr,
    input  logic  cuJR,
    input  word_t jr_addr,
    input  logic  cujmp,
    input  word_t jmp_addr,
    input  word_t pc,
    output logic  redirect,
    output word_t target,
    output word_t pc_plus4
);

    word_t raw_target_s;

    // Select the highest-priority redirect source.
    always_comb begin
        raw_target_s = jmp_addr;
        if (val_brnch) begin
            raw_target_s = brnch_addr;
        end else if (cuJR) begin
            raw_target_s = jr_addr;
        end else begin
            raw_target_s = jmp_addr;
        end
    end

    assign redirect = val_brnch | cuJR | cujmp;
    assign target   = align_word(raw_target_s);
    assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request, one-entry stall buffer and IF/ID latch.
// Define FETCH_STATS_EN to build the saturating fetch/flush counters.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter int    WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              ifW,
    input  logic              ifRST,
    input  logic              val_brnch,
    input  logic [WORD_W-1:0] brnch_addr,
    input  logic              cuJR,
    input  logic [WORD_W-1:0] jr_addr,
    input  logic              cujmp,
    input  logic [WORD_W-1:0] jmp_addr,
    input  logic              cuHALT,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_npc,
    output logic              ifid_valid,
    output logic              halted,
    output logic [WORD_W-1:0] fetch_cnt,
    output logic [WORD_W-1:0] flush_cnt
);

    fetch_state_t state_r;
    word_t        pc_r;
    word_t        hold_instr_r;
    word_t        hold_pc_r;
    word_t        ifid_instr_r;
    word_t        ifid_npc_r;
    logic         ifid_valid_r;
    logic         halted_r;
    logic         imemren_r;

    logic  redirect_s;
    word_t target_s;
    word_t pc_plus4_s;
    logic  halt_s;
    logic  avail_s;
    logic  latch_en_s;
    logic  latch_valid_s;
    word_t latch_instr_s;
    word_t latch_npc_s;

    pc_next_mux u_pc_next_mux (
        .val_brnch  (val_brnch),
        .brnch_addr (brnch_addr),
        .cuJR       (cuJR),
        .jr_addr    (jr_addr),
        .cujmp      (cujmp),
        .jmp_addr   (jmp_addr),
        .pc         (pc_r),
        .redirect   (redirect_s),
        .target     (target_s),
        .pc_plus4   (pc_plus4_s)
    );

    // A halt on the wrong path (redirect) or while ID is stalled is not taken.
    assign halt_s  = cuHALT & ~redirect_s & ifW;
    assign avail_s = (state_r == HOLD) | ((state_r == FETCH) & ihit & ~redirect_s);

    // IF/ID latch next value; in HOLD the PC already sits at buffered PC+4.
    always_comb begin
        latch_en_s    = 1'b0;
        latch_valid_s = 1'b0;
        latch_instr_s = BUBBLE_INSTR;
        latch_npc_s   = 32'h0000_0000;
        if (state_r == HALTED) begin
            latch_en_s = 1'b0;
        end else if (ifRST) begin
            latch_en_s = 1'b1;
        end else if (ifW) begin
            latch_en_s = 1'b1;
            if (avail_s && !halt_s) begin
                latch_valid_s = 1'b1;
                latch_instr_s = (state_r == HOLD) ? hold_instr_r : imemload;
                latch_npc_s   = (state_r == HOLD) ? pc_r : pc_plus4_s;
            end else begin
                latch_valid_s = 1'b0;
            end
        end else begin
            latch_en_s = 1'b0;
        end
    end

    // Fetch FSM with PC, stall buffer, IF/ID latch and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= FETCH;
            pc_r         <= PC_INIT;
            hold_instr_r <= BUBBLE_INSTR;
            hold_pc_r    <= 32'h0000_0000;
            ifid_instr_r <= BUBBLE_INSTR;
            ifid_npc_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
            halted_r     <= 1'b0;
            imemren_r    <= 1'b1;
        end else if (state_r == HALTED) begin
            state_r <= HALTED;
        end else begin
            if (latch_en_s) begin
                ifid_instr_r <= latch_instr_s;
                ifid_npc_r   <= latch_npc_s;
                ifid_valid_r <= latch_valid_s;
            end
            if (redirect_s) begin
                pc_r      <= target_s;
                state_r   <= FETCH;
                imemren_r <= 1'b1;
            end else if (halt_s) begin
                state_r   <= HALTED;
                halted_r  <= 1'b1;
                imemren_r <= 1'b0;
            end else begin
                case (state_r)
                    FETCH: begin
                        if (ihit && !ifRST) begin
                            pc_r <= pc_plus4_s;
                            if (!ifW) begin
                                hold_instr_r <= imemload;
                                hold_pc_r    <= pc_r;
                                state_r      <= HOLD;
                                imemren_r    <= 1'b0;
                            end
                        end
                    end
                    HOLD: begin
                        // A flushed buffer is refetched from its own address.
                        if (ifRST) begin
                            pc_r      <= hold_pc_r;
                            state_r   <= FETCH;
                            imemren_r <= 1'b1;
                        end else if (ifW) begin
                            state_r   <= FETCH;
                            imemren_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end
        end
    end

`ifdef FETCH_STATS_EN
    word_t fetch_cnt_r;
    word_t flush_cnt_r;

    // Saturating statistics counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_cnt_r <= 32'h0000_0000;
            flush_cnt_r <= 32'h0000_0000;
        end else begin
            if (latch_en_s && latch_valid_s && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
            if ((state_r != HALTED) && ifRST && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign fetch_cnt = 32'h0000_0000;
    assign flush_cnt = 32'h0000_0000;
`endif

    assign imemREN    = imemren_r;
    assign imemaddr   = pc_r;
    assign ifid_instr = ifid_instr_r;
    assign ifid_npc   = ifid_npc_r;
    assign ifid_valid = ifid_valid_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and random bench for fetch_stage against a queue-based reference model.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST, ihit, ifW, ifRST, val_brnch, cuJR, cujmp, cuHALT;
    logic [31:0] imemload, brnch_addr, jr_addr, jmp_addr;
    logic        imemREN, ifid_valid, halted;
    logic [31:0] imemaddr, ifid_instr, ifid_npc, fetch_cnt, flush_cnt;

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .ifW(ifW), .ifRST(ifRST),
        .val_brnch(val_brnch), .brnch_addr(brnch_addr), .cuJR(cuJR), .jr_addr(jr_addr),
        .cujmp(cujmp), .jmp_addr(jmp_addr), .cuHALT(cuHALT),
        .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    bit rand_data = 1'b0;

    // Reference model: PC, pending buffered fetches, halted flag, latch contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } held_t;
    held_t       held_q[$];
    logic [31:0] m_pc, m_instr, m_npc;
    bit          m_valid, m_halted;
    longint      m_fcnt, m_flcnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_step();
        logic [31:0] tgt, ins, npc;
        bit redir, have_held, has_instr, do_halt;
        held_t h;
        if (RST) begin
            m_pc = 32'h0; m_halted = 0; held_q.delete();
            m_instr = 32'h0; m_npc = 32'h0; m_valid = 0; m_fcnt = 0; m_flcnt = 0;
        end else if (!m_halted) begin
            redir = val_brnch || cuJR || cujmp;
            tgt = val_brnch ? brnch_addr : (cuJR ? jr_addr : jmp_addr);
            tgt = tgt & 32'hFFFF_FFFC;
            have_held = (held_q.size() != 0);
            has_instr = have_held || (ihit && !redir);
            if (have_held) begin
                h = held_q[0]; ins = h.instr; npc = h.pc + 32'd4;
            end else begin
                ins = imemload; npc = m_pc + 32'd4;
            end
            do_halt = cuHALT && !redir && ifW;
            if (ifRST) begin
                m_instr = 32'h0; m_npc = 32'h0; m_valid = 0;
                if (m_flcnt < 64'hFFFF_FFFF) m_flcnt++;
            end else if (ifW) begin
                if (has_instr && !do_halt) begin
                    m_instr = ins; m_npc = npc; m_valid = 1;
                    if (m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
                end else begin
                    m_instr = 32'h0; m_npc = 32'h0; m_valid = 0;
                end
            end
            if (redir) begin
                m_pc = tgt; held_q.delete();
            end else if (do_halt) begin
                m_halted = 1; held_q.delete();
            end else if (have_held) begin
                if (ifRST) begin
                    m_pc = held_q[0].pc; held_q.delete();
                end else if (ifW) begin
                    held_q.delete();
                end
            end else if (ihit && !ifRST) begin
                if (!ifW) held_q.push_back('{instr: imemload, pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_f, e_fl;
`ifdef FETCH_STATS_EN
        e_f = m_fcnt[31:0]; e_fl = m_flcnt[31:0];
`else
        e_f = 32'h0; e_fl = 32'h0;
`endif
        chk("imemaddr", imemaddr, m_pc);
        chk("imemREN", {31'h0, imemREN}, {31'h0, !m_halted && held_q.size() == 0});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_npc", ifid_npc, m_npc);
        chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
        chk("halted", {31'h0, halted}, {31'h0, m_halted});
        chk("fetch_cnt", fetch_cnt, e_f);
        chk("flush_cnt", flush_cnt, e_fl);
    endtask

    task automatic idle();
        RST = 0; ihit = 0; ifW = 0; ifRST = 0; val_brnch = 0; cuJR = 0; cujmp = 0;
        cuHALT = 0; brnch_addr = 32'h0; jr_addr = 32'h0; jmp_addr = 32'h0;
    endtask

    task automatic step();
        if (!rand_data) imemload = mem_word(imemaddr);
        model_step();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    initial begin
        idle();
        imemload = 32'h0;
        // Reset
        RST = 1; step(); step();
        chk("reset_pc", imemaddr, 32'h0000_0000);
        // Sequential fetch 0,4
        idle(); ihit = 1; ifW = 1; step(); step();
        chk("seq_npc", ifid_npc, 32'd8);
        // Stall capture at PC=8, then release
        idle(); ihit = 1; ifW = 0; step();
        chk("stall_ren", {31'h0, imemREN}, 32'h0);
        chk("stall_pc", imemaddr, 32'd12);
        idle(); ifW = 1; step();
        chk("hold_instr", ifid_instr, mem_word(32'd8));
        chk("hold_npc", ifid_npc, 32'd12);
        // Branch beats jump, flush in same cycle
        idle(); ihit = 1; ifW = 1; val_brnch = 1; brnch_addr = 32'h40;
        cujmp = 1; jmp_addr = 32'h80; ifRST = 1; step();
        chk("brnch_pc", imemaddr, 32'h40);
        // Flush in HOLD with no redirect rolls PC back
        idle(); ihit = 1; ifW = 0; step();
        idle(); ifRST = 1; step();
        chk("hold_flush_pc", imemaddr, 32'h40);
        idle(); ihit = 1; ifW = 1; step();
        // Flush with ihit in FETCH refetches same address
        idle(); ihit = 1; ifW = 1; ifRST = 1; step();
        // Halt, then inputs ignored for 10 cycles
        idle(); cuHALT = 1; ifW = 1; ihit = 1; step();
        for (int i = 0; i < 10; i++) begin
            idle(); ihit = 1; ifW = 1; ifRST = i[0]; cuJR = i[1]; jr_addr = 32'h100; step();
        end
        chk("halted_hold", {31'h0, halted}, 32'h1);
        idle(); RST = 1; step();
        chk("halt_reset", {31'h0, halted}, 32'h0);
        // Misaligned jr redirect and wrap at 2^32
        idle(); cuJR = 1; jr_addr = 32'hFFFF_FFFE; step();
        chk("wrap_tgt", imemaddr, 32'hFFFF_FFFC);
        idle(); ihit = 1; ifW = 1; step();
        chk("wrap_pc", imemaddr, 32'h0000_0000);
        // Random phase
        rand_data = 1'b1;
        for (int i = 0; i < 600; i++) begin
            idle();
            RST        = ($urandom_range(99) < 2);
            ihit       = ($urandom_range(99) < 70);
            ifW        = ($urandom_range(99) < 70);
            ifRST      = ($urandom_range(99) < 10);
            val_brnch  = ($urandom_range(99) < 5);
            cuJR       = ($urandom_range(99) < 5);
            cujmp      = ($urandom_range(99) < 5);
            cuHALT     = ($urandom_range(99) < 3);
            brnch_addr = $urandom; jr_addr = $urandom; jmp_addr = $urandom;
            imemload   = $urandom;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
